spm_stream_reader: RTL

- Read-side DMA engine for the dual-port scratchpad memory (SPM).
- Owns one SPM port and sweeps a contiguous word range starting at base_addr.
- Streams the words out on a valid/ready interface, with a small buffer that absorbs the RAM's 1-cycle registered read latency and any consumer backpressure.
- Consumers are bus bridges, peripheral feeders and the debug dump path.

---
 rtl/spm_stream_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spm_stream_reader.sv
// Read-side DMA engine for the scratchpad: sweeps a contiguous word range on one
// SPM port and streams the words out on valid/ready through a 3-entry skid FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; FIFO empty, nothing in flight
// ST_RUN   | issuing reads while issue counter != 0 and buffer has room
// ST_DRAIN | all reads issued; waiting for the last beat to leave

module spm_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_we,
    output logic [DATA_W-1:0] spm_wdata,
    input  logic [DATA_W-1:0] spm_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [3];
    logic [DATA_W-1:0] fifo_d [3];
    logic [1:0]        rd_q, rd_d;
    logic [1:0]        wr_q, wr_d;
    logic [1:0]        count_q, count_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic              drain_done;
    logic [2:0]        occupancy;

    // Words buffered plus the one possibly on its way from the RAM must leave a
    // free slot, so a read issued now always has somewhere to land.
    always_comb begin
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
        issue      = (state_q == ST_RUN) && (issue_cnt_q != '0) && (occupancy < 3'd3);
        push       = inflight_q;
        pop        = (count_q != 2'd0) && out_ready;
        drain_done = (state_q == ST_DRAIN) && (beat_cnt_q == '0) && !inflight_q;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;

        if (pop) begin
            beat_cnt_d = beat_cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    issue_cnt_d = length;
                    beat_cnt_d  = length;
                    state_d     = (length != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    ptr_d       = ptr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                end
                if (issue_cnt_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        spm_addr    = issue ? ptr_q : addr_hold_q;
        addr_hold_d = spm_addr;
        spm_we      = 1'b0;
        spm_wdata   = '0;
        busy        = (state_q != ST_IDLE);
        done        = drain_done;
    end

    // Circular 3-entry FIFO; read data is only captured on the cycle after an issue.
    always_comb begin
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;

        if (push) begin
            fifo_d[wr_q] = spm_rdata;
            wr_d         = (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        out_valid = (count_q != 2'd0);
        out_data  = fifo_q[rd_q];
        out_last  = out_valid && (beat_cnt_q == {{ADDR_W{1'b0}}, 1'b1});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            addr_hold_q <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            rd_q        <= 2'd0;
            wr_q        <= 2'd0;
            count_q     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            addr_hold_q <= addr_hold_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule
